// File: rtl/ahb_arbiter_rr.sv
// rtl/ahb_arbiter_rr.sv - round-robin AHB bus arbiter with burst, lock and split/retry awareness
`timescale 1ns/1ps
module ahb_arbiter_rr #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK,
  output logic [3:0]             HMASTER_D
);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;
  localparam logic [2:0] BURST_INCR   = 3'd1;
  localparam logic [1:0] RESP_OKAY    = 2'd0;
  localparam logic [3:0] DEF_IDX      = 4'(DEFAULT_MASTER);

  // The grant register doubles as the round-robin pointer: the search
  // always starts just above whoever currently holds the grant.
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [3:0]             beats_q, beats_d;
  logic                   incr_q, incr_d;
  logic [3:0]             master_q, master_d;
  logic                   mastlock_q, mastlock_d;
  logic [3:0]             master_dph_q, master_dph_d;

  logic [15:0] req_pad;
  logic [15:0] lock_pad;
  logic [3:0]  owner_idx;
  logic [3:0]  next_idx;
  logic [3:0]  start_len;
  logic        resp_err;
  logic        burst_busy;
  logic        incr_hold;
  logic        permit;

  assign req_pad  = 16'(HBUSREQ);
  assign lock_pad = 16'(HLOCK);
  assign resp_err = (HRESP != RESP_OKAY);

  // Decode the one-hot grant into the owner index.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) owner_idx = 4'(i);
    end
  end

  // Remaining SEQ beats implied by the burst type of a NONSEQ.
  always_comb begin
    case (HBURST)
      3'd2, 3'd3: start_len = 4'd3;
      3'd4, 3'd5: start_len = 4'd7;
      3'd6, 3'd7: start_len = 4'd15;
      default:    start_len = 4'd0;
    endcase
  end

  // Decide whether the grant may move this cycle. A NONSEQ that opens a
  // fixed-length burst already counts as busy so the owner keeps the bus
  // for its first beat; an INCR burst is held only by the owner's request.
  always_comb begin
    if (HTRANS == TRANS_NONSEQ) begin
      burst_busy = (start_len != 4'd0);
    end else begin
      burst_busy = (beats_q > 4'd1) || ((beats_q == 4'd1) && (HTRANS != TRANS_SEQ));
    end
    incr_hold = req_pad[owner_idx] &&
                (((HTRANS == TRANS_NONSEQ) && (HBURST == BURST_INCR)) ||
                 (incr_q && ((HTRANS == TRANS_SEQ) || (HTRANS == TRANS_BUSY))));
    permit = HREADY && !lock_pad[owner_idx] && (resp_err || (!burst_busy && !incr_hold));
  end

  // Round-robin search from owner+1 upward, wrapping, ending on the owner.
  always_comb begin
    logic       found;
    logic [4:0] cand;
    found    = 1'b0;
    next_idx = DEF_IDX;
    cand     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = 5'(owner_idx) + 5'(i);
      if (cand >= 5'(NUM_MASTERS)) cand = cand - 5'(NUM_MASTERS);
      if (!found && req_pad[cand[3:0]]) begin
        found    = 1'b1;
        next_idx = cand[3:0];
      end
    end
  end

  // Next-state for grant, burst tracking and the ownership pipeline.
  always_comb begin
    grant_d      = grant_q;
    beats_d      = beats_q;
    incr_d       = incr_q;
    master_d     = master_q;
    mastlock_d   = mastlock_q;
    master_dph_d = master_dph_q;

    if (permit) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        grant_d[i] = (4'(i) == next_idx);
      end
    end

    if (resp_err) begin
      beats_d = 4'd0;
      incr_d  = 1'b0;
    end else if (HREADY && (HTRANS == TRANS_NONSEQ)) begin
      beats_d = start_len;
      incr_d  = (HBURST == BURST_INCR);
    end else if (HREADY && (HTRANS == TRANS_SEQ)) begin
      if (beats_q != 4'd0) beats_d = beats_q - 4'd1;
    end else if (HREADY && (HTRANS == TRANS_IDLE)) begin
      incr_d = 1'b0;
    end

    if (HREADY) begin
      master_d     = owner_idx;
      mastlock_d   = lock_pad[owner_idx];
      master_dph_d = master_q;
    end

    if (reset) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        grant_d[i] = (4'(i) == DEF_IDX);
      end
      beats_d      = 4'd0;
      incr_d       = 1'b0;
      master_d     = DEF_IDX;
      mastlock_d   = 1'b0;
      master_dph_d = DEF_IDX;
    end
  end

  // State registers; reset is folded into the next-state logic above.
  always_ff @(posedge clock) begin
    grant_q      <= grant_d;
    beats_q      <= beats_d;
    incr_q       <= incr_d;
    master_q     <= master_d;
    mastlock_q   <= mastlock_d;
    master_dph_q <= master_dph_d;
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;
  assign HMASTER_D = master_dph_q;

endmodule

// File: doc/ahb_arbiter_rr.md
AHB_ARBITER_RR -- requirements
Module: ahb_arbiter_rr

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 3, giving the number of bus masters; legal range 2..16.
REQ-002 The block SHALL have parameter DEFAULT_MASTER, default 0, giving the master index granted when no master requests.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port HBUSREQ, input, NUM_MASTERS bits: per-master bus request.
REQ-006 The block SHALL have port HLOCK, input, NUM_MASTERS bits: per-master locked-transfer request.
REQ-007 The block SHALL have port HTRANS, input, 2 bits: muxed address-phase transfer type of the current owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 The block SHALL have port HBURST, input, 3 bits: muxed burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
REQ-009 The block SHALL have port HREADY, input, 1 bit: muxed slave ready.
REQ-010 The block SHALL have port HRESP, input, 2 bits: muxed slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
REQ-011 The block SHALL have port HGRANT, output, NUM_MASTERS bits: one-hot grant, registered.
REQ-012 The block SHALL have port HMASTER, output, 4 bits: index of the address-phase owner, registered.
REQ-013 The block SHALL have port HMASTLOCK, output, 1 bit: address-phase transfer is locked, registered.
REQ-014 The block SHALL have port HMASTER_D, output, 4 bits: index of the data-phase owner, registered.

Function
REQ-015 HGRANT SHALL be exactly one-hot in every cycle after reset.
REQ-016 Burst counter beats_left SHALL load on HREADY=1 with HTRANS=NONSEQ: 3 for WRAP4/INCR4, 7 for WRAP8/INCR8, 15 for WRAP16/INCR16, 0 for SINGLE/INCR.
REQ-017 beats_left SHALL decrement by 1 on HREADY=1 with HTRANS=SEQ while nonzero, and hold on BUSY or HREADY=0.
REQ-018 beats_left SHALL clear to 0 on any cycle with HRESP=ERROR, RETRY or SPLIT (early burst termination).
REQ-019 Re-arbitration SHALL be permitted only when HREADY=1, owner's HLOCK=0, and (beats_left=0, or beats_left=1 with HTRANS=SEQ).
REQ-020 When permitted, the next owner SHALL be the first requesting master searching upward from (owner+1) modulo NUM_MASTERS, wrapping, ending with the owner itself.
REQ-021 If no HBUSREQ bit is set when re-arbitration is permitted, HGRANT SHALL select DEFAULT_MASTER.
REQ-022 An undefined-length INCR burst SHALL be held only while the owner keeps HBUSREQ high; SEQ/BUSY alone SHALL NOT block re-arbitration for INCR.
REQ-023 New grant SHALL appear on HGRANT one cycle after the permitting edge.
REQ-024 HMASTER SHALL load the index of HGRANT on each edge with HREADY=1, and hold otherwise.
REQ-025 HMASTLOCK SHALL load HLOCK[granted index] on each edge with HREADY=1.
REQ-026 HMASTER_D SHALL load HMASTER on each edge with HREADY=1: a two-stage address/data ownership pipeline.
REQ-027 Requests and lock from masters not granted SHALL not affect HMASTLOCK.

Reset
REQ-028 With reset=1 at an edge: HGRANT = one-hot DEFAULT_MASTER, HMASTER = HMASTER_D = DEFAULT_MASTER, HMASTLOCK=0, beats_left=0, round-robin pointer = DEFAULT_MASTER, regardless of bus activity mid-transfer.

Verification
REQ-029 Reset, then all HBUSREQ=0 for 5 cycles -> HGRANT=001, HMASTER=0, HMASTER_D=0, HMASTLOCK=0.
REQ-030 N=3, HBUSREQ=111 held, HTRANS=NONSEQ SINGLE, HREADY=1 -> HGRANT sequence 001,010,100,001 (strict rotation).
REQ-031 M1 starts INCR4 (NONSEQ then 3 SEQ), M2 requesting throughout -> HGRANT stays on M1 until the edge of the last SEQ, then 100; HMASTER_D trails HMASTER by one HREADY edge.
REQ-032 M0 HLOCK=1 with HBUSREQ=111 for 6 cycles -> HGRANT=001 and HMASTLOCK=1 throughout; after HLOCK drops, grant moves to M1.
REQ-033 INCR8 owned by M0 with HRESP=RETRY on beat 3 -> beats_left=0 and grant passes to next requester; HREADY=0 for 4 cycles -> HGRANT, HMASTER, HMASTER_D all hold.
